// File: rtl/hex_scan_mux.sv
// Time-multiplexed hex digit scanner for a common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZ_BLANK_EN.
module hex_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            rez,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame_tick
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] ONE = DIGITS'(1);

  logic [CNT_W-1:0]    prescaler;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_q;
  logic [4*DIGITS-1:0] pending;
  logic [4*DIGITS-1:0] shadow;
  logic                q_valid;
  logic                blank_q;
  logic                tc;
  logic                wrap;
  logic                blank_now;

  assign tc   = en && (prescaler == CNT_W'(SCAN_DIV - 1));
  assign wrap = tc && (idx == IDX_W'(DIGITS - 1));

`ifdef HEX_SCAN_LZ_BLANK_EN
  // lz_blank[k] is set when shadow digits k..DIGITS-1 are all zero (k > 0).
  logic [DIGITS-1:0] lz_blank;
  logic              upper_zero;

  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero  = upper_zero && (shadow[4*k +: 4] == 4'h0);
      lz_blank[k] = upper_zero;
    end
  end

  assign blank_now = lz_blank[idx];
`else
  assign blank_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler  <= '0;
      idx        <= '0;
      idx_q      <= '0;
      pending    <= '0;
      shadow     <= '0;
      q_valid    <= 1'b0;
      blank_q    <= 1'b0;
      rez        <= 4'h0;
      dig_n      <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (load) pending <= value;

      if (en) begin
        // Stage 1 picks the nibble; stage 2 drives the anode of the digit
        // that stage 1 presented, matching the decoder's register delay.
        idx_q   <= idx;
        rez     <= shadow[{idx, 2'b00} +: 4];
        blank_q <= blank_now;
        q_valid <= 1'b1;
        dig_n   <= (q_valid && !blank_q) ? ~(ONE << idx_q) : '1;

        if (tc) begin
          prescaler <= '0;
          if (wrap) begin
            idx        <= '0;
            shadow     <= load ? value : pending;
            frame_tick <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end else begin
          prescaler <= prescaler + CNT_W'(1);
        end
      end else begin
        // idx_q is stale while frozen; hold anodes off until it re-aligns.
        q_valid <= 1'b0;
        dig_n   <= '1;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_mux.sv
// Directed bench for hex_scan_mux with DIGITS=4, SCAN_DIV=4; the blanking
// expectations follow HEX_SCAN_LZ_BLANK_EN when it is defined.
module tb_hex_scan_mux;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  rez;
  logic [3:0]  dig_n;
  logic        frame_tick;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] model_prev  = 16'h0000;

  always #5 clk = ~clk;

  hex_scan_mux #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .value      (value),
    .rez        (rez),
    .dig_n      (dig_n),
    .frame_tick (frame_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic blank(input int j, input logic [15:0] s);
`ifdef HEX_SCAN_LZ_BLANK_EN
    return (j != 0) && ((s >> (4 * j)) == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] slot(input int j, input logic [15:0] s);
    logic [3:0] one;
    one = 4'b0001;
    return blank(j, s) ? 4'b1111 : ~(one << j);
  endfunction

  // Walks ncyc cycles of a frame starting just after a frame_tick edge.
  task automatic check_frame(input logic [15:0] val, input int ld_k, input int ld_c,
                             input logic [15:0] ld_val, input int ncyc);
    int n;
    logic [3:0] exp_dig;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (n < ncyc) begin
          if (k == ld_k && c == ld_c) begin
            load  = 1'b1;
            value = ld_val;
          end
          step();
          load = 1'b0;
          if (c != 0)      exp_dig = slot(k, val);
          else if (k == 0) exp_dig = slot(3, model_prev);
          else             exp_dig = slot(k - 1, val);
          chk($sformatf("rez[%h] d%0d c%0d", val, k, c), 16'(rez), 16'(val[4*k +: 4]));
          chk($sformatf("dig_n[%h] d%0d c%0d", val, k, c), 16'(dig_n), 16'(exp_dig));
          chk($sformatf("frame_tick[%h] d%0d c%0d", val, k, c), 16'(frame_tick),
              (k == 3 && c == 3) ? 16'd1 : 16'd0);
          n++;
        end
      end
    end
    if (ncyc >= 16) model_prev = val;
  endtask

  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_tick !== 1'b1 && n < max);
  endtask

  task automatic startup();
    int n;
    rst = 1'b0;
    en  = 1'b1;
    step();
    chk("start_dig_n_e1", 16'(dig_n), 16'h000F);
    chk("start_rez_e1", 16'(rez), 16'h0000);
    chk("start_tick_e1", 16'(frame_tick), 16'h0000);
    step();
    chk("start_dig_n_e2", 16'(dig_n), 16'h000E);
    chk("start_rez_e2", 16'(rez), 16'h0000);
    wait_tick(40, n);
    chk("first_wrap_cycles", 16'(n), 16'd14);
    model_prev = 16'h0000;
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    value = 16'h0000;

    repeat (3) begin
      step();
      chk("reset_dig_n", 16'(dig_n), 16'h000F);
      chk("reset_rez", 16'(rez), 16'h0000);
      chk("reset_tick", 16'(frame_tick), 16'h0000);
    end

    startup();

    // Zero frame, then 1234, then ABCD loaded mid-frame, then 5678 on the wrap.
    check_frame(16'h0000, 0, 0, 16'h1234, 16);
    check_frame(16'h1234, 1, 0, 16'hABCD, 16);
    check_frame(16'hABCD, 3, 3, 16'h5678, 16);
    check_frame(16'h5678, -1, 0, 16'h0000, 16);

    // Freeze at digit 2 with prescaler at 2.
    check_frame(16'h5678, -1, 0, 16'h0000, 10);
    en = 1'b0;
    repeat (10) begin
      step();
      chk("frozen_dig_n", 16'(dig_n), 16'h000F);
      chk("frozen_rez", 16'(rez), 16'h0006);
      chk("frozen_tick", 16'(frame_tick), 16'h0000);
    end
    en = 1'b1;
    step();
    chk("resume_dig_n_r1", 16'(dig_n), 16'h000F);
    chk("resume_rez_r1", 16'(rez), 16'h0006);
    step();
    chk("resume_dig_n_r2", 16'(dig_n), 16'h000B);
    chk("resume_rez_r2", 16'(rez), 16'h0006);
    step();
    chk("resume_dig_n_r3", 16'(dig_n), 16'h000B);
    chk("resume_rez_r3", 16'(rez), 16'h0005);
    step();
    chk("resume_dig_n_r4", 16'(dig_n), 16'h0007);
    chk("resume_rez_r4", 16'(rez), 16'h0005);
    wait_tick(20, n);
    chk("resume_wrap_cycles", 16'(n), 16'd2);
    check_frame(16'h5678, -1, 0, 16'h0000, 16);

    // Reset in the middle of a frame.
    check_frame(16'h5678, -1, 0, 16'h0000, 6);
    rst = 1'b1;
    step();
    chk("midreset_dig_n", 16'(dig_n), 16'h000F);
    chk("midreset_rez", 16'(rez), 16'h0000);
    chk("midreset_tick", 16'(frame_tick), 16'h0000);
    startup();

    // Leading-zero patterns.
    check_frame(16'h0000, 0, 0, 16'h0050, 16);
    check_frame(16'h0050, 2, 1, 16'h0000, 16);
    check_frame(16'h0000, -1, 0, 16'h0000, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
